// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the switch debouncer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: per-bit FSM state enum, default debounce length.
package switch_debouncer_pkg;

  // Per-bit debounce state: STABLE while sync2 matches the accepted level,
  // PENDING while a candidate new level is being qualified.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_t;

  // 10 ms at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage : switch_debouncer_pkg

// File: rtl/switch_debounce_bit.sv
// Single-bit switch conditioner: 2-flop synchronizer, stability counter,
// STABLE/PENDING FSM and registered rise/fall pulses.
// Latency: raw level sampled at edge k appears on o_level at edge k+DEBOUNCE_CYCLES+1.
// Backpressure: none; free-running, one sample per clock.
// Ports:
//   clk, reset       - rising-edge clock, async active-high reset
//   i_raw            - asynchronous switch pin
//   o_level          - debounced level (registered)
//   o_rise / o_fall  - one-cycle pulses coincident with o_level changing
//   o_rise_nxt/_nxt  - combinational "pulse next edge" flags, used by the top
//                      to register an aligned any-change pulse
module switch_debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_nxt,
  output logic o_fall_nxt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  deb_state_t       r_state;

  logic             w_differs;
  logic             w_accept;

  // Metastability guard: nothing downstream looks at i_raw or r_sync1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_differs = r_sync2 ^ r_stable;

  // The candidate has now been seen for DEBOUNCE_CYCLES consecutive cycles
  // (this edge included), so it becomes the accepted level at this edge.
  assign w_accept   = (r_state == PENDING) && w_differs && (r_cnt == CNT_LAST);
  assign o_rise_nxt = w_accept &  r_sync2;
  assign o_fall_nxt = w_accept & ~r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= STABLE;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= o_rise_nxt;
      r_fall <= o_fall_nxt;
      case (r_state)
        STABLE: begin
          if (w_differs) begin
            r_state <= PENDING;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        PENDING: begin
          if (!w_differs) begin
            // Glitch: candidate vanished before qualifying.
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (w_accept) begin
            r_stable <= r_sync2;
            r_state  <= STABLE;
            r_cnt    <= '0;
          end else begin
            // Cannot wrap: acceptance at CNT_LAST always clears the count.
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level = r_stable;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule : switch_debounce_bit

// File: rtl/switch_debouncer.sv
// WIDTH-bit switch debouncer feeding the switches PIO, with edge pulses.
// Latency: DEBOUNCE_CYCLES+1 clocks from first sync1 sample to sw_out.
// Backpressure: none; free-running, one sample per clock.
// Ports:
//   clk, reset  - rising-edge clock, async active-high reset
//   sw_raw      - asynchronous switch pins
//   sw_out      - debounced registered levels
//   sw_rise     - per-bit one-cycle pulse on sw_out 0->1
//   sw_fall     - per-bit one-cycle pulse on sw_out 1->0
//   sw_changed  - one-cycle pulse, OR of all rise/fall pulses, same cycle
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] w_fall_nxt;
  logic             r_changed;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .i_raw      (sw_raw[g]),
      .o_level    (sw_out[g]),
      .o_rise     (sw_rise[g]),
      .o_fall     (sw_fall[g]),
      .o_rise_nxt (w_rise_nxt[g]),
      .o_fall_nxt (w_fall_nxt[g])
    );
  end

  // Registered from the same next-edge flags as the per-bit pulses, so it
  // lines up with them exactly and multiple simultaneous bits give one pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign sw_changed = r_changed;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (WIDTH=10, DEBOUNCE_CYCLES=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_switch_debouncer;

  localparam int W = 10;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_out;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  switch_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .sw_out     (sw_out),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } exp_t;

  exp_t         sb_q[$];
  // smp[i] = sw_raw value sampled i edges ago (smp[0] = this edge).
  logic [W-1:0] smp [0:D+1];
  logic [W-1:0] m_lvl;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           k0 = 0;
  int           ph_chg = 0;
  int           ph_rise_cyc = -1;
  logic [W-1:0] ph_rise = '0;
  logic [W-1:0] ph_fall = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: a level is accepted at edge n when the D samples taken at
  // edges n-D-1 .. n-2 (the two-flop delay) all hold it and it differs from
  // the current output.
  task automatic model_edge(input logic [W-1:0] raw, input bit in_rst);
    exp_t         e;
    logic [W-1:0] r;
    logic [W-1:0] f;
    r = '0;
    f = '0;
    if (in_rst) begin
      for (int i = 0; i <= D + 1; i++) smp[i] = '0;
      m_lvl = '0;
    end else begin
      for (int i = D + 1; i > 0; i--) smp[i] = smp[i-1];
      smp[0] = raw;
      for (int b = 0; b < W; b++) begin
        logic a1;
        logic a0;
        a1 = 1'b1;
        a0 = 1'b1;
        for (int i = 2; i <= D + 1; i++) begin
          a1 = a1 &  smp[i][b];
          a0 = a0 & ~smp[i][b];
        end
        r[b] = ~m_lvl[b] & a1;
        f[b] =  m_lvl[b] & a0;
      end
      m_lvl = (m_lvl | r) & ~f;
    end
    e.lvl  = m_lvl;
    e.rise = r;
    e.fall = f;
    e.chg  = |(r | f);
    sb_q.push_back(e);
  endtask

  task automatic check_edge();
    exp_t e;
    chk("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sw_out",     32'(sw_out),     32'(e.lvl));
      chk("sw_rise",    32'(sw_rise),    32'(e.rise));
      chk("sw_fall",    32'(sw_fall),    32'(e.fall));
      chk("sw_changed", 32'(sw_changed), 32'(e.chg));
    end
    ph_chg  = ph_chg + int'(sw_changed);
    ph_rise = ph_rise | sw_rise;
    ph_fall = ph_fall | sw_fall;
    if (sw_rise != '0 && ph_rise_cyc < 0) ph_rise_cyc = cyc;
  endtask

  task automatic step(input logic [W-1:0] raw);
    @(negedge clk);
    sw_raw = raw;
    model_edge(raw, 1'b0);
    @(posedge clk);
    #1;
    cyc++;
    check_edge();
  endtask

  task automatic step_rst();
    @(negedge clk);
    model_edge(sw_raw, 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    check_edge();
  endtask

  task automatic phase_clear();
    ph_chg      = 0;
    ph_rise     = '0;
    ph_fall     = '0;
    ph_rise_cyc = -1;
  endtask

  initial begin
    for (int i = 0; i <= D + 1; i++) smp[i] = '0;
    m_lvl = '0;

    // Power-on reset, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_out",  32'(sw_out),     32'd0);
    chk("rst_rise", 32'(sw_rise),    32'd0);
    chk("rst_fall", 32'(sw_fall),    32'd0);
    chk("rst_chg",  32'(sw_changed), 32'd0);
    repeat (3) step_rst();
    reset = 1'b0;

    // Idle with all switches low.
    phase_clear();
    repeat (20) step(10'h000);
    chk("idle_chg", 32'(ph_chg), 32'd0);

    // Bit 0 rises and is held: accepted exactly D+1 edges after first sample.
    phase_clear();
    step(10'h001);
    k0 = cyc;
    repeat (9) step(10'h001);
    chk("b0_latency", 32'(ph_rise_cyc - k0), 32'(D + 1));
    chk("b0_chg_cnt", 32'(ph_chg), 32'd1);
    chk("b0_rise",    32'(ph_rise), 32'h001);

    // Bit 3 high for only D-1 cycles: rejected.
    phase_clear();
    repeat (3) step(10'h009);
    repeat (10) step(10'h001);
    chk("b3_chg_cnt", 32'(ph_chg), 32'd0);
    chk("b3_out",     32'(sw_out), 32'h001);

    repeat (8) step(10'h000);

    // All bits together: one sw_changed, then nine falls at once.
    phase_clear();
    repeat (8) step(10'h3FF);
    chk("all_chg_cnt", 32'(ph_chg),  32'd1);
    chk("all_rise",    32'(ph_rise), 32'h3FF);
    phase_clear();
    repeat (8) step(10'h200);
    chk("fall_chg_cnt", 32'(ph_chg),  32'd1);
    chk("fall_mask",    32'(ph_fall), 32'h1FF);

    // Asynchronous clear of a non-zero output between clock edges.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_out", 32'(sw_out),     32'd0);
    chk("arst_chg", 32'(sw_changed), 32'd0);
    repeat (2) step_rst();
    reset = 1'b0;
    repeat (8) step(10'h000);

    // Bit 5 pending for two cycles when reset hits; must requalify afterwards.
    phase_clear();
    repeat (4) step(10'h020);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("pend_rst_out", 32'(sw_out), 32'd0);
    repeat (2) step_rst();
    reset = 1'b0;
    chk("pend_rst_chg_cnt", 32'(ph_chg), 32'd0);
    phase_clear();
    step(10'h020);
    k0 = cyc;
    repeat (9) step(10'h020);
    chk("b5_latency", 32'(ph_rise_cyc - k0), 32'(D + 1));
    chk("b5_chg_cnt", 32'(ph_chg),  32'd1);
    chk("b5_rise",    32'(ph_rise), 32'h020);

    // Bit 2 chattering every cycle: never accepted.
    phase_clear();
    for (int i = 0; i < 50; i++) step((i % 2 == 0) ? 10'h024 : 10'h020);
    repeat (6) step(10'h020);
    chk("tog_chg_cnt", 32'(ph_chg), 32'd0);
    chk("tog_out",     32'(sw_out), 32'h020);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_switch_debouncer

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, number of switch inputs conditioned.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), consecutive stable cycles required to accept a new level; legal range 2..2^24.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sw_raw, input, WIDTH, asynchronous board switch pins.
REQ-006 SHALL have port sw_out, output, WIDTH, debounced registered levels feeding the switches PIO in_port.
REQ-007 SHALL have port sw_rise, output, WIDTH, one-cycle pulse per bit when sw_out bit goes 0->1.
REQ-008 SHALL have port sw_fall, output, WIDTH, one-cycle pulse per bit when sw_out bit goes 1->0.
REQ-009 SHALL have port sw_changed, output, 1, one-cycle pulse, OR of all sw_rise and sw_fall bits.

Function
REQ-010 SHALL pass each sw_raw bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-011 SHALL keep per bit a stable level, a counter of width clog2(DEBOUNCE_CYCLES), and a two-state FSM: STABLE, PENDING.
REQ-012 STABLE: sync2 == stable -> stay, counter 0; sync2 != stable -> PENDING, counter 1.
REQ-013 PENDING: sync2 == stable -> STABLE, counter 0 (glitch rejected, no output change).
REQ-014 PENDING: sync2 != stable and counter < DEBOUNCE_CYCLES-1 -> counter +1.
REQ-015 PENDING: sync2 != stable and counter == DEBOUNCE_CYCLES-1 -> stable <= sync2, counter 0, STABLE.
REQ-016 Latency: sw_raw level first sampled by sync1 at edge k and held SHALL appear on sw_out at edge k+DEBOUNCE_CYCLES+1; never earlier.
REQ-017 Any sync2 pulse shorter than DEBOUNCE_CYCLES cycles SHALL produce no sw_out change and no pulse.
REQ-018 sw_rise/sw_fall SHALL be registered, asserted exactly the cycle sw_out shows the new level, for one cycle.
REQ-019 sw_changed SHALL be registered and coincident with the sw_rise/sw_fall pulses that cause it.
REQ-020 Bits SHALL be fully independent; simultaneous acceptance on several bits SHALL raise all their pulses in the same cycle and a single sw_changed pulse.
REQ-021 Counter SHALL never wrap; it saturates by construction at DEBOUNCE_CYCLES-1 via REQ-015.
REQ-022 sw_out SHALL not change when sw_raw is unchanged, regardless of counter state.

Reset
REQ-023 reset SHALL asynchronously clear sync1, sync2, stable/sw_out, counters, FSM (STABLE), sw_rise, sw_fall, sw_changed to 0.
REQ-024 Reset asserted mid-PENDING SHALL discard the pending count; no pulse after deassertion unless re-qualified per REQ-016.
REQ-025 After reset release with a switch held high, that bit SHALL qualify per REQ-016 and emit one sw_rise.

Structure
REQ-026 Shared package SHALL hold the FSM state enum (STABLE, PENDING) and the default DEBOUNCE_CYCLES constant.
REQ-027 Per-bit logic (synchronizer, counter, FSM, edge pulse) SHALL be one sub-module switch_debounce_bit, instantiated WIDTH times; top aggregates sw_changed.
REQ-028 Counter width SHALL derive from DEBOUNCE_CYCLES via clog2, no hard-coded widths.

Verification (DEBOUNCE_CYCLES=4, WIDTH=10)
REQ-029 Reset, sw_raw=0x000 held 20 cycles -> sw_out=0x000, no pulses.
REQ-030 sw_raw bit0 0->1 sampled at edge k, held -> sw_out=0x001 and sw_rise=0x001, sw_changed=1 at edge k+5 only, one cycle.
REQ-031 sw_raw bit3 high for 3 cycles then low -> sw_out unchanged, no pulses.
REQ-032 sw_raw 0x000->0x3FF same edge -> sw_out=0x3FF, sw_rise=0x3FF, single sw_changed pulse same cycle; then 0x3FF->0x200 -> sw_fall=0x1FF.
REQ-033 bit5 rising, reset asserted after 2 PENDING cycles, released with bit5 still high -> sw_out bit5 rises 5 edges after first post-reset sample, one sw_rise.
REQ-034 bit2 toggling every cycle for 50 cycles -> sw_out bit2 never changes.
